bsg_activation_sched: RTL and testbench

- Round-robin scheduler that shares one bsg_activation unit (tanh/sigmoid) among num_clients_p requesters.
- Accepts per-client angle/function requests and issues them one at a time to the unit.
- Holds each request's operands stable for the whole operation and routes the result back to the originating client.
- Sits between the client array (e.g. neuron lanes) and the single activation datapath.

---
 rtl/bsg_activation_sched_pkg.sv | 18 +
 rtl/bsg_activation_sched_if.sv | 38 +++
 rtl/bsg_activation_sched_rr_arb.sv | 30 +++
 rtl/bsg_activation_sched.sv | 125 ++++++++++++
 tb/tb_bsg_activation_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_activation_sched_pkg.sv
// Shared types and constants for the activation-unit round-robin scheduler.
package bsg_activation_sched_pkg;

  typedef enum logic [1:0] {
    e_IDLE  = 2'd0,
    e_ISSUE = 2'd1,
    e_WAIT  = 2'd2,
    e_RESP  = 2'd3
  } state_e;

  // 1.0 in the 16-fractional-bit result format
  localparam logic [31:0] fx_one_gp = 32'h0001_0000;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_activation_sched_if.sv
// Client-side and activation-unit-side handshake bundle of the scheduler.
interface bsg_activation_sched_if #(
  parameter int num_clients_p = 4,
  parameter int ang_width_p   = 21,
  parameter int ans_width_p   = 32
);

  logic [num_clients_p-1:0]             req_v_i;
  logic [num_clients_p*ang_width_p-1:0] req_ang_i;
  logic [num_clients_p-1:0]             req_tanh_sel_i;
  logic [num_clients_p-1:0]             req_ready_o;
  logic [num_clients_p-1:0]             resp_v_o;
  logic [ans_width_p-1:0]               resp_data_o;
  logic [num_clients_p-1:0]             resp_ready_i;

  logic [ang_width_p-1:0]               act_ang_o;
  logic                                 act_tanh_sel_o;
  logic                                 act_v_o;
  logic                                 act_ready_i;
  logic [ans_width_p-1:0]               act_data_i;
  logic                                 act_v_i;
  logic                                 act_yumi_o;

  modport master (
    input  req_v_i, req_ang_i, req_tanh_sel_i, resp_ready_i,
    input  act_ready_i, act_data_i, act_v_i,
    output req_ready_o, resp_v_o, resp_data_o,
    output act_ang_o, act_tanh_sel_o, act_v_o, act_yumi_o
  );

  modport slave (
    output req_v_i, req_ang_i, req_tanh_sel_i, resp_ready_i,
    output act_ready_i, act_data_i, act_v_i,
    input  req_ready_o, resp_v_o, resp_data_o,
    input  act_ang_o, act_tanh_sel_o, act_v_o, act_yumi_o
  );

endinterface

// File: rtl/bsg_activation_sched_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr_i+1, wrapping.
module bsg_activation_sched_rr_arb #(
  parameter int num_clients_p = 4,
  parameter int lg_clients_lp = 2
) (
  input  logic [num_clients_p-1:0] req_i,
  input  logic [lg_clients_lp-1:0] ptr_i,
  output logic                     v_o,
  output logic [num_clients_p-1:0] grant_o,
  output logic [lg_clients_lp-1:0] id_o
);

  always_comb begin
    int  idx;
    logic found;
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    for (int i = 0; i < num_clients_p; i++) begin
      idx = (int'(ptr_i) + 1 + i) % num_clients_p;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx[lg_clients_lp-1:0];
      end
    end
    v_o = found;
  end

endmodule

// File: rtl/bsg_activation_sched.sv
// Shares one tanh/sigmoid activation unit among several clients, one operation
// in flight, with operands held in registers from grant through result pickup.
module bsg_activation_sched
  import bsg_activation_sched_pkg::*;
#(
  parameter int num_clients_p = 4,
  parameter int ang_width_p   = 21,
  parameter int ans_width_p   = 32,
  localparam int lg_clients_lp = safe_clog2(num_clients_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bsg_activation_sched_if.master bus,
  output logic                   busy_o
);

  state_e                   state_q, state_d;
  logic [ang_width_p-1:0]   ang_q;
  logic                     sel_q;
  logic [lg_clients_lp-1:0] id_q;
  logic [lg_clients_lp-1:0] ptr_q;
  logic [ans_width_p-1:0]   res_q;

  logic                     arb_v;
  logic [num_clients_p-1:0] arb_grant;
  logic [lg_clients_lp-1:0] arb_id;

  logic                     accept, capture;
  logic [num_clients_p-1:0] req_ready, resp_v;
  logic                     act_v, yumi;

  bsg_activation_sched_rr_arb #(
    .num_clients_p(num_clients_p),
    .lg_clients_lp(lg_clients_lp)
  ) u_arb (
    .req_i  (bus.req_v_i),
    .ptr_i  (ptr_q),
    .v_o    (arb_v),
    .grant_o(arb_grant),
    .id_o   (arb_id)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    resp_v    = '0;
    act_v     = 1'b0;
    yumi      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      e_IDLE: begin
        if (arb_v) begin
          accept    = 1'b1;
          req_ready = arb_grant;
          state_d   = e_ISSUE;
        end
      end
      // A same-cycle act_v_i (bypass unit) is left pending and consumed in e_WAIT.
      e_ISSUE: begin
        act_v = 1'b1;
        if (bus.act_ready_i) state_d = e_WAIT;
      end
      e_WAIT: begin
        if (bus.act_v_i) begin
          yumi    = 1'b1;
          capture = 1'b1;
          state_d = e_RESP;
        end
      end
      e_RESP: begin
        resp_v[id_q] = 1'b1;
        if (bus.resp_ready_i[id_q]) state_d = e_IDLE;
      end
      default: state_d = e_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= e_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ang_q <= '0;
      sel_q <= 1'b0;
      id_q  <= '0;
      ptr_q <= lg_clients_lp'(num_clients_p - 1);
      res_q <= '0;
    end else begin
      if (accept) begin
        ang_q <= bus.req_ang_i[arb_id*ang_width_p +: ang_width_p];
        sel_q <= bus.req_tanh_sel_i[arb_id];
        id_q  <= arb_id;
        ptr_q <= arb_id;
      end
      if (capture) res_q <= bus.act_data_i;
    end
  end

  // The grant is combinational from req_v_i, so it must be masked during reset.
  assign bus.req_ready_o    = reset_n_i ? req_ready : '0;
  assign bus.resp_v_o       = resp_v;
  assign bus.resp_data_o    = res_q;
  assign bus.act_ang_o      = ang_q;
  assign bus.act_tanh_sel_o = sel_q;
  assign bus.act_v_o        = act_v;
  assign bus.act_yumi_o     = yumi;
  assign busy_o             = (state_q != e_IDLE);

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(bus.req_ready_o))
        else $error("bsg_activation_sched: req_ready_o not one-hot");
      assert ($onehot0(bus.resp_v_o))
        else $error("bsg_activation_sched: resp_v_o not one-hot");
      assert (!(state_q == e_IDLE && bus.act_v_i))
        else $error("bsg_activation_sched: act_v_i seen while idle");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_activation_sched.sv
// Directed bench for the activation scheduler with a latency/bypass stub unit.
module tb_bsg_activation_sched;
  import bsg_activation_sched_pkg::*;

  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  always #5 clk = ~clk;

  bsg_activation_sched_if #(.num_clients_p(N), .ang_width_p(AW), .ans_width_p(DW)) bus_if ();

  bsg_activation_sched #(.num_clients_p(N), .ang_width_p(AW), .ans_width_p(DW)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus_if),
    .busy_o   (busy)
  );

  int checks = 0;
  int errors = 0;

  // Stub activation unit: fixed latency, or same-cycle bypass result.
  int          stub_lat    = 10;
  bit          stub_bypass = 1'b0;
  logic [31:0] stub_ret    = '0;
  logic        stub_busy, stub_vld;
  int          stub_cnt;

  assign bus_if.act_ready_i = !stub_busy && !stub_vld;
  assign bus_if.act_v_i     = stub_vld || (stub_bypass && bus_if.act_v_o && bus_if.act_ready_i);
  assign bus_if.act_data_i  = stub_ret;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0;
      stub_vld  <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      if (stub_vld && bus_if.act_yumi_o) stub_vld <= 1'b0;
      if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          stub_vld  <= 1'b1;
        end else stub_cnt <= stub_cnt - 1;
      end else if (bus_if.act_v_o && bus_if.act_ready_i && !stub_vld) begin
        if (stub_bypass) stub_vld <= 1'b1;
        else begin
          stub_busy <= 1'b1;
          stub_cnt  <= stub_lat;
        end
      end
    end
  end

  int yumi_cnt  = 0;
  int multi_cnt = 0;
  always @(posedge clk) begin
    if (rst_n && bus_if.act_yumi_o) yumi_cnt <= yumi_cnt + 1;
    if ($countones(bus_if.req_ready_o) > 1 || $countones(bus_if.resp_v_o) > 1)
      multi_cnt <= multi_cnt + 1;
  end

  task automatic clear_inputs();
    bus_if.req_v_i        = '0;
    bus_if.req_ang_i      = '0;
    bus_if.req_tanh_sel_i = '0;
    bus_if.resp_ready_i   = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_resp(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus_if.resp_v_o != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus_if.req_v_i = 4'b0101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b0000) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus_if.req_ready_o);
    end
    checks++;
    if ({bus_if.resp_v_o, bus_if.act_v_o, bus_if.act_yumi_o, bus_if.act_tanh_sel_o, busy} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got resp_v=%b act_v=%b yumi=%b sel=%b busy=%b expected all 0",
                         bus_if.resp_v_o, bus_if.act_v_o, bus_if.act_yumi_o, bus_if.act_tanh_sel_o, busy);
    end
    checks++;
    if (bus_if.resp_data_o !== 32'h0 || bus_if.act_ang_o !== 21'h0) begin
      errors++; $display("FAIL reset_data: got data=%h ang=%h expected 0", bus_if.resp_data_o, bus_if.act_ang_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b0001) begin
      errors++; $display("FAIL reset_first_priority: got %b expected 0001", bus_if.req_ready_o);
    end
    bus_if.req_v_i = '0;
  endtask

  task automatic test_single();
    bit ok;
    int y0;
    @(posedge clk); #1;
    stub_lat = 10; stub_ret = 32'h0000_7660; y0 = yumi_cnt;
    bus_if.req_v_i = 4'b0001;
    bus_if.req_ang_i[0*AW +: AW] = 21'h08000;
    bus_if.req_tanh_sel_i = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b expected 0001", bus_if.req_ready_o);
    end
    @(posedge clk); #1 bus_if.req_v_i = '0;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b0000 || bus_if.act_v_o !== 1'b1 ||
        bus_if.act_ang_o !== 21'h08000 || bus_if.act_tanh_sel_o !== 1'b1) begin
      errors++; $display("FAIL single_issue: got ready=%b act_v=%b ang=%h sel=%b expected 0000 1 08000 1",
                         bus_if.req_ready_o, bus_if.act_v_o, bus_if.act_ang_o, bus_if.act_tanh_sel_o);
    end
    wait_resp(60, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout: got no response expected one within 60 cycles");
    end
    checks++;
    if (bus_if.resp_v_o !== 4'b0001 || bus_if.resp_data_o !== 32'h0000_7660) begin
      errors++; $display("FAIL single_resp: got v=%b data=%h expected 0001 00007660",
                         bus_if.resp_v_o, bus_if.resp_data_o);
    end
    checks++;
    if (yumi_cnt - y0 !== 1) begin
      errors++; $display("FAIL single_yumi: got %0d pulses expected 1", yumi_cnt - y0);
    end
    @(posedge clk); #1 bus_if.resp_ready_i = 4'b0001;
    @(posedge clk); #1 bus_if.resp_ready_i = '0;
    @(negedge clk);
    checks++;
    if (bus_if.resp_v_o !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done: got v=%b busy=%b expected 0000 0", bus_if.resp_v_o, busy);
    end
  endtask

  task automatic test_round_robin();
    int got = 0;
    int m0;
    logic [3:0] exp;
    apply_reset();
    m0 = multi_cnt;
    stub_lat = 2; stub_ret = 32'h0000_0042;
    bus_if.req_v_i = 4'b1111;
    bus_if.resp_ready_i = 4'b1111;
    for (int c = 0; c < 300 && got < 8; c++) begin
      @(negedge clk);
      if (bus_if.req_ready_o != '0) begin
        exp = 4'b0001 << (got % 4);
        checks++;
        if (bus_if.req_ready_o !== exp) begin
          errors++; $display("FAIL rr_order[%0d]: got %b expected %b", got, bus_if.req_ready_o, exp);
        end
        got++;
        if (got == 8) bus_if.req_v_i = '0;
      end
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL rr_count: got %0d grants expected 8", got);
    end
    checks++;
    if (multi_cnt != m0) begin
      errors++; $display("FAIL rr_onehot: got %0d multi-hot cycles expected 0", multi_cnt - m0);
    end
    bus_if.resp_ready_i = '0;
  endtask

  task automatic test_operand_hold();
    bit ok, seen;
    int bad;
    @(posedge clk); #1;
    stub_lat = 10; stub_ret = 32'hFFFF_3D1C;
    bus_if.req_v_i = 4'b0100;
    bus_if.req_ang_i[2*AW +: AW] = 21'h1F0000;
    bus_if.req_tanh_sel_i = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b0100) begin
      errors++; $display("FAIL hold_grant: got %b expected 0100", bus_if.req_ready_o);
    end
    @(posedge clk); #1;
    bus_if.req_v_i = '0;
    bus_if.req_ang_i = '1;
    bus_if.req_tanh_sel_i = '1;
    bad = 0; seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus_if.act_ang_o !== 21'h1F0000 || bus_if.act_tanh_sel_o !== 1'b0) bad++;
      if (bus_if.act_yumi_o) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL hold_timeout: got no yumi expected one within 60 cycles");
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_operands: got %0d cycles disturbed expected 0 (ang=%h sel=%b)",
                         bad, bus_if.act_ang_o, bus_if.act_tanh_sel_o);
    end
    wait_resp(5, ok);
    checks++;
    if (!ok || bus_if.resp_v_o !== 4'b0100 || bus_if.resp_data_o !== 32'hFFFF_3D1C) begin
      errors++; $display("FAIL hold_resp: got v=%b data=%h expected 0100 ffff3d1c",
                         bus_if.resp_v_o, bus_if.resp_data_o);
    end
    @(posedge clk); #1 bus_if.resp_ready_i = 4'b0100;
    @(posedge clk); #1 clear_inputs();
  endtask

  task automatic test_bypass();
    bit ok;
    int y0;
    @(posedge clk); #1;
    stub_bypass = 1'b1; stub_ret = fx_one_gp; y0 = yumi_cnt;
    bus_if.req_v_i = 4'b0001;
    bus_if.req_ang_i[0*AW +: AW] = 21'h40000;
    bus_if.req_tanh_sel_i = 4'b0001;
    @(posedge clk); #1 bus_if.req_v_i = '0;
    wait_resp(20, ok);
    checks++;
    if (!ok || bus_if.resp_v_o !== 4'b0001 || bus_if.resp_data_o !== 32'h0001_0000) begin
      errors++; $display("FAIL bypass_resp: got ok=%b v=%b data=%h expected 1 0001 00010000",
                         ok, bus_if.resp_v_o, bus_if.resp_data_o);
    end
    @(posedge clk); #1 bus_if.resp_ready_i = 4'b0001;
    @(posedge clk); #1 bus_if.resp_ready_i = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (yumi_cnt - y0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL bypass_yumi: got %0d pulses busy=%b expected 1 0", yumi_cnt - y0, busy);
    end
    stub_bypass = 1'b0;
    clear_inputs();
  endtask

  task automatic test_backpressure();
    bit ok;
    int b_rdy = 0, b_busy = 0, b_resp = 0;
    @(posedge clk); #1;
    stub_lat = 3; stub_ret = 32'h1234_5678;
    bus_if.req_v_i = 4'b0010;
    bus_if.resp_ready_i = 4'b1001;
    @(posedge clk); #1 bus_if.req_v_i = '0;
    wait_resp(40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_timeout: got no response expected one within 40 cycles");
    end
    bus_if.req_v_i = 4'b1001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_if.req_ready_o !== 4'b0000) b_rdy++;
      if (busy !== 1'b1) b_busy++;
      if (bus_if.resp_v_o !== 4'b0010 || bus_if.resp_data_o !== 32'h1234_5678) b_resp++;
    end
    checks++;
    if (b_rdy != 0) begin
      errors++; $display("FAIL bp_no_grant: got %0d granting cycles expected 0", b_rdy);
    end
    checks++;
    if (b_busy != 0) begin
      errors++; $display("FAIL bp_busy: got %0d idle cycles expected 0", b_busy);
    end
    checks++;
    if (b_resp != 0) begin
      errors++; $display("FAIL bp_resp_stable: got %0d unstable cycles expected 0", b_resp);
    end
    @(posedge clk); #1 bus_if.resp_ready_i = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b1000) begin
      errors++; $display("FAIL bp_next_grant: got %b expected 1000", bus_if.req_ready_o);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    stub_lat = 10; stub_ret = 32'h0000_ABCD;
    bus_if.req_v_i = 4'b0100;
    bus_if.req_ang_i[2*AW +: AW] = 21'h01234;
    bus_if.req_tanh_sel_i = 4'b0100;
    @(posedge clk); #1 bus_if.req_v_i = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.act_v_o !== 1'b0 || busy !== 1'b1 || bus_if.act_ang_o !== 21'h01234) begin
      errors++; $display("FAIL midrst_setup: got act_v=%b busy=%b ang=%h expected 0 1 01234",
                         bus_if.act_v_o, busy, bus_if.act_ang_o);
    end
    #2;
    rst_n = 1'b0;
    bus_if.req_v_i = 4'b1111;
    #1;
    checks++;
    if ({bus_if.req_ready_o, bus_if.resp_v_o, bus_if.act_v_o, bus_if.act_yumi_o,
         bus_if.act_tanh_sel_o, busy} !== 12'h000) begin
      errors++; $display("FAIL midrst_ctrl: got ready=%b resp_v=%b act_v=%b yumi=%b sel=%b busy=%b expected all 0",
                         bus_if.req_ready_o, bus_if.resp_v_o, bus_if.act_v_o, bus_if.act_yumi_o,
                         bus_if.act_tanh_sel_o, busy);
    end
    checks++;
    if (bus_if.act_ang_o !== 21'h0 || bus_if.resp_data_o !== 32'h0) begin
      errors++; $display("FAIL midrst_data: got ang=%h data=%h expected 0", bus_if.act_ang_o, bus_if.resp_data_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready_o !== 4'b0001) begin
      errors++; $display("FAIL midrst_first: got %b expected 0001", bus_if.req_ready_o);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_operand_hold();
    test_bypass();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
